clk_enable_gen: RTL and testbench
=================================

// Module: clk_enable_gen
// PURPOSE
//  Parametrised, runtime-reprogrammable clock-enable generator on the board reference clock.
//  Produces NUM_CH divided channels, each with a one-cycle enable strobe and a square-wave level.
//  Channels are phase-programmable and re-alignable, with a locked flag after every change.
//  Downstream logic stays single-clock: it gates on ce_out instead of consuming derived clocks.
// PARAMETERS
//  NUM_CH       2                      number of output channels (1..16)
//  DIV_W        16                     divisor/phase width in bits
//  CH_W         $clog2(NUM_CH) (min 1) channel-select width
//  DIV_INIT     {16'd2,16'd5}          packed NUM_CH*DIV_W reset divisors, ch0 in LSBs (10/25 MHz @50 MHz)
//  LOCK_PERIODS 4                      strobes of the tracked channel required before locked asserts
// PORTS
//  refclk     in   1           sole clock; all logic rising-edge
//  rst_n      in   1           synchronous active-low reset
//  cfg_valid  in   1           config request
//  cfg_ready  out  1           config accept; transfer when cfg_valid && cfg_ready
//  cfg_ch     in   CH_W        channel to program
//  cfg_div    in   DIV_W       new divisor (0 = disable channel)
//  cfg_phase  in   DIV_W       counter load value applied with the new divisor
//  resync     in   1           one-cycle pulse: reload every channel counter with its phase
//  ce_out     out  NUM_CH      per-channel enable strobe, 1 cycle wide
//  lvl_out    out  NUM_CH      per-channel divided level
//  locked     out  1           outputs stable since last reset/config/resync
// BEHAVIOUR
//  Reset (rst_n=0 at an edge):
//  - div[i]=DIV_INIT[i], phase[i]=0, cnt[i]=0, ce_out=0, lvl_out=0, locked=0.
//  - cfg_ready=0; state=RELOCK; tracked channel=0.
//  Counter:
//  - For div>=2: cnt[i] counts 0..div-1 then wraps to 0, every cycle.
//  - Outputs are registered: ce_out[i] <= (cnt[i]==div[i]-1); lvl_out[i] <= (cnt[i] < div[i]>>1).
//  - Period = div cycles. ce_out is high once per period, in the cycle cnt reads 0.
//  - lvl_out is high floor(div/2) cycles, low ceil(div/2) cycles.
//  - div==1: ce_out=1 every cycle, lvl_out=0.
//  - div==0: cnt held 0, ce_out=0, lvl_out=0.
//  FSM: RELOCK, LOCKED, APPLY.
//  - cfg_ready = (state != APPLY) && rst_n.
//  - Accept (any state except APPLY) -> APPLY for one cycle.
//  - In APPLY, if cfg_ch < NUM_CH:
//    - div[ch]<=cfg_div.
//    - cnt[ch]<=(cfg_phase<cfg_div ? cfg_phase : 0).
//    - phase[ch] stores that same value.
//    - tracked<=ch, lock count<=0, locked<=0.
//    - Next state RELOCK.
//  - In APPLY, if cfg_ch >= NUM_CH: no register change; return to the state held before accept.
//  - resync pulse (any state): all cnt[i]<=phase[i]; lock count<=0; locked<=0; -> RELOCK.
//    - Tracked channel unchanged.
//    - resync coinciding with APPLY: APPLY's channel update and resync both take effect that edge.
//  - RELOCK:
//    - Lock count increments on each ce_out[tracked].
//    - At count==LOCK_PERIODS -> LOCKED; locked=1 the next cycle.
//    - If div[tracked]==0 -> LOCKED after one RELOCK cycle.
//  - LOCKED holds until an accept, a resync, or reset.
//  - Reset mid-RELOCK or mid-APPLY restores all reset values; the pending config is discarded.
//  - Lock count saturates; its width is $clog2(LOCK_PERIODS+1).
//  - Other channels free-run undisturbed during any config/resync.
// TESTING
//  1 Release rst_n at cycle 0 (defaults):
//    - ce_out[0] high at cycles 5,10,15,20.
//    - lvl_out[0] pattern 1,1,0,0,0 per period.
//    - ce_out[1] high every 2 cycles; locked=1 from cycle 21.
//  2 Write ch1 div=4 phase=1 while LOCKED:
//    - cfg_ready low 1 cycle; locked falls.
//    - ce_out[1] period 4; locked returns after 4 ch1 strobes; ch0 strobe times unchanged.
//  3 Write ch0 div=0:
//    - ce_out[0], lvl_out[0] stuck 0 one cycle after APPLY.
//    - locked reasserts immediately after one RELOCK cycle.
//  4 Set ch0 phase=0, ch1 div=5 phase=3, then pulse resync:
//    - ch1 strobes exactly 2 cycles after ch0 in every period thereafter.
//    - locked drops, then relocks.
//  5 cfg_ch=3 with NUM_CH=2:
//    - Accepted; no output change; locked stays 1.
//  6 Assert rst_n=0 during RELOCK after a config:
//    - All outputs 0.
//    - After release, ch1 is back to div 2 and the default sequence of test 1 repeats.

Source files
------------

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: runtime-reprogrammable clock-enable generator.
// Each channel divides refclk by its own divisor. It produces a one-cycle
// enable strobe (ce_out) and a square-wave level (lvl_out). Consumers gate on
// the strobe, so they never see a derived clock. A small FSM applies one
// channel update at a time. It reports "locked" once the most recently touched
// channel has produced LOCK_PERIODS strobes.

module clk_enable_gen #(
    parameter int                        NUM_CH       = 2,
    parameter int                        DIV_W        = 16,
    parameter int                        CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter logic [NUM_CH*DIV_W-1:0]   DIV_INIT     = {16'd2, 16'd5},
    parameter int                        LOCK_PERIODS = 4
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [DIV_W-1:0]    cfg_phase,
    input  logic                resync,
    output logic [NUM_CH-1:0]   ce_out,
    output logic [NUM_CH-1:0]   lvl_out,
    output logic                locked
);

    localparam int LCNT_W = $clog2(LOCK_PERIODS + 1);

    localparam logic [1:0] ST_RELOCK = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_APPLY  = 2'd2;

    localparam logic [CH_W:0]       NUM_CH_C = (CH_W + 1)'(NUM_CH);
    localparam logic [LCNT_W-1:0]   LOCK_TGT = LCNT_W'(LOCK_PERIODS);
    localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0]   div_q   [NUM_CH];
    logic [DIV_W-1:0]   phase_q [NUM_CH];
    logic [DIV_W-1:0]   cnt_q   [NUM_CH];
    logic [DIV_W-1:0]   cnt_free[NUM_CH];
    logic [NUM_CH-1:0]  ce_nxt;
    logic [NUM_CH-1:0]  lvl_nxt;

    logic [1:0]         state;
    logic [1:0]         prev_state;
    logic [CH_W-1:0]    tracked;
    logic [LCNT_W-1:0]  lock_cnt;
    logic [LCNT_W-1:0]  lock_inc;

    logic [CH_W-1:0]    pend_ch;
    logic [DIV_W-1:0]   pend_div;
    logic [DIV_W-1:0]   pend_phase;
    logic [DIV_W-1:0]   pend_load;
    logic               pend_ok;
    logic               apply_hit;
    logic               accept;

    logic               trk_ce;
    logic               trk_div_zero;

    assign cfg_ready = (state != ST_APPLY) && rst_n;
    assign accept    = cfg_valid && cfg_ready;
    assign pend_ok   = ({1'b0, pend_ch} < NUM_CH_C);
    assign apply_hit = (state == ST_APPLY) && pend_ok;
    // A phase outside the new period would never be reached, so start at 0.
    assign pend_load = (pend_phase < pend_div) ? pend_phase : '0;
    assign lock_inc  = (lock_cnt == LOCK_TGT) ? lock_cnt : lock_cnt + LCNT_W'(1);

    // Free-running next count and next registered outputs per channel; div==0 parks everything at 0
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_free[i] = '0;
            ce_nxt[i]   = 1'b0;
            lvl_nxt[i]  = 1'b0;
            if (div_q[i] != '0) begin
                if (cnt_q[i] < div_q[i] - DIV_ONE) begin
                    cnt_free[i] = cnt_q[i] + DIV_ONE;
                end
                ce_nxt[i]  = (cnt_q[i] == div_q[i] - DIV_ONE);
                lvl_nxt[i] = (cnt_q[i] < (div_q[i] >> 1));
            end
        end
    end

    // Pick out the strobe and divisor state of the channel the lock detector watches
    always_comb begin
        trk_ce       = 1'b0;
        trk_div_zero = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tracked == CH_W'(i)) begin
                trk_ce       = ce_out[i];
                trk_div_zero = (div_q[i] == '0);
            end
        end
    end

    // Per-channel counters, divisor/phase storage and registered outputs
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]   <= DIV_INIT[i*DIV_W +: DIV_W];
                phase_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            ce_out  <= '0;
            lvl_out <= '0;
        end else begin
            ce_out  <= ce_nxt;
            lvl_out <= lvl_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                if (apply_hit && (pend_ch == CH_W'(i))) begin
                    div_q[i]   <= pend_div;
                    phase_q[i] <= pend_load;
                    cnt_q[i]   <= pend_load;
                end else if (resync) begin
                    cnt_q[i] <= phase_q[i];
                end else begin
                    cnt_q[i] <= cnt_free[i];
                end
            end
        end
    end

    // Config handshake, lock tracking and RELOCK/LOCKED/APPLY sequencing
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state      <= ST_RELOCK;
            prev_state <= ST_RELOCK;
            tracked    <= '0;
            lock_cnt   <= '0;
            locked     <= 1'b0;
            pend_ch    <= '0;
            pend_div   <= '0;
            pend_phase <= '0;
        end else begin
            if (accept) begin
                pend_ch    <= cfg_ch;
                pend_div   <= cfg_div;
                pend_phase <= cfg_phase;
                prev_state <= resync ? ST_RELOCK : state;
            end
            if (resync) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
                state    <= accept ? ST_APPLY : ST_RELOCK;
                if (apply_hit) begin
                    tracked <= pend_ch;
                end
            end else if (accept) begin
                state <= ST_APPLY;
            end else begin
                case (state)
                    ST_APPLY: begin
                        if (pend_ok) begin
                            tracked  <= pend_ch;
                            lock_cnt <= '0;
                            locked   <= 1'b0;
                            state    <= ST_RELOCK;
                        end else begin
                            state <= prev_state;
                        end
                    end
                    ST_RELOCK: begin
                        if (trk_div_zero) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end else if (trk_ce) begin
                            lock_cnt <= lock_inc;
                            if (lock_inc == LOCK_TGT) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        state <= ST_LOCKED;
                    end
                    default: begin
                        state <= ST_RELOCK;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// tb_clk_enable_gen: directed bench for clk_enable_gen with default channel
// setup (ch0 /5, ch1 /2). cfg_ch is widened to 2 bits so that an out-of-range
// channel number can be presented. "Cycle n" means the values seen just after
// the n-th rising edge following reset release. Each check compares the
// vector {locked, lvl_out[1], lvl_out[0], ce_out[1], ce_out[0]}.

module tb_clk_enable_gen;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 16;
    localparam int CH_W   = 2;

    logic               refclk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [CH_W-1:0]    cfg_ch = '0;
    logic [DIV_W-1:0]   cfg_div = '0;
    logic [DIV_W-1:0]   cfg_phase = '0;
    logic               resync = 1'b0;
    logic [NUM_CH-1:0]  ce_out;
    logic [NUM_CH-1:0]  lvl_out;
    logic               locked;

    int compared = 0;
    int mismatched = 0;
    int n = 0;

    // Free-running reference clock
    always #5 refclk = ~refclk;

    clk_enable_gen #(
        .NUM_CH(NUM_CH),
        .DIV_W(DIV_W),
        .CH_W(CH_W),
        .DIV_INIT({16'd2, 16'd5}),
        .LOCK_PERIODS(4)
    ) dut (
        .refclk(refclk),
        .rst_n(rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_phase(cfg_phase),
        .resync(resync),
        .ce_out(ce_out),
        .lvl_out(lvl_out),
        .locked(locked)
    );

    task automatic checkOutput(input string tag, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("[TB] FAIL %s cycle %0d: got 'h%0h expected 'h%0h", tag, n, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
        n++;
    endtask

    task automatic applyStimulus(input logic v, input logic [CH_W-1:0] ch,
                                 input logic [DIV_W-1:0] d, input logic [DIV_W-1:0] p,
                                 input logic rs);
        cfg_valid = v;
        cfg_ch    = ch;
        cfg_div   = d;
        cfg_phase = p;
        resync    = rs;
    endtask

    function automatic int observed();
        return int'({locked, lvl_out, ce_out});
    endfunction

    function automatic int vec(input bit lk, input bit l1, input bit l0, input bit c1, input bit c0);
        return int'({lk, l1, l0, c1, c0});
    endfunction

    // ch0 at default /5 from reset: strobe when n%5==0, level high for n%5 in {1,2}
    function automatic bit ch0Lvl(input int k);
        return (k % 5 == 1) || (k % 5 == 2);
    endfunction

    task automatic resetDut();
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("rst_outputs", observed(), 0);
        checkOutput("rst_ready", int'(cfg_ready), 0);
        rst_n = 1'b1;
        n = 0;
    endtask

    // Default sequence: ch0 /5, ch1 /2, locked after four ch0 strobes (cycle 21)
    task automatic runDefault(input string tag);
        for (int k = 0; k < 21; k++) begin
            tick();
            checkOutput(tag, observed(),
                        vec(n >= 21, n % 2 == 1, ch0Lvl(n), n % 2 == 0, n % 5 == 0));
        end
    endtask

    initial begin
        applyStimulus(1'b0, '0, '0, '0, 1'b0);

        // Test 1: defaults from reset
        resetDut();
        runDefault("t1_default");

        // Test 2: ch1 -> div 4, phase 1 while LOCKED
        checkOutput("t2_ready_idle", int'(cfg_ready), 1);
        applyStimulus(1'b1, 2'd1, 16'd4, 16'd1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        checkOutput("t2_ready_apply", int'(cfg_ready), 0);
        checkOutput("t2_vec", observed(),
                    vec(1'b1, (n + 1) % 4 < 2, ch0Lvl(n), n % 4 == 2, n % 5 == 0));
        while (n < 40) begin
            tick();
            if (n == 23) checkOutput("t2_ready_back", int'(cfg_ready), 1);
            checkOutput("t2_vec", observed(),
                        vec(n >= 39, (n + 1) % 4 < 2, ch0Lvl(n), n % 4 == 2, n % 5 == 0));
        end

        // Test 3: ch0 -> div 0
        applyStimulus(1'b1, 2'd0, 16'd0, 16'd0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        checkOutput("t3_vec", observed(),
                    vec(1'b1, (n + 1) % 4 < 2, ch0Lvl(n), n % 4 == 2, n % 5 == 0));
        while (n < 46) begin
            tick();
            checkOutput("t3_vec", observed(),
                        vec(n != 42, (n + 1) % 4 < 2, (n <= 42) && ch0Lvl(n),
                            n % 4 == 2, (n <= 42) && (n % 5 == 0)));
        end

        // Test 4: ch0 div 5 phase 0, ch1 div 5 phase 3, then resync (twice)
        applyStimulus(1'b1, 2'd0, 16'd5, 16'd0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'd1, 16'd5, 16'd3, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        tick();
        resync = 1'b0;
        while (n < 95) begin
            if (n == 75) resync = 1'b1;
            tick();
            if (n == 76) resync = 1'b0;
            checkOutput("t4_vec", observed(),
                        vec(((n >= 69) && (n < 76)) || (n >= 94),
                            (n - 51 + 2) % 5 < 2, (n - 51 - 1) % 5 < 2,
                            (n - 51) % 5 == 2, (n - 51) % 5 == 0));
        end

        // Test 5: out-of-range channel is accepted and ignored
        checkOutput("t5_ready_idle", int'(cfg_ready), 1);
        applyStimulus(1'b1, 2'd3, 16'd7, 16'd1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        checkOutput("t5_ready_apply", int'(cfg_ready), 0);
        checkOutput("t5_vec", observed(),
                    vec(1'b1, (n - 49) % 5 < 2, (n - 52) % 5 < 2,
                        (n - 51) % 5 == 2, (n - 51) % 5 == 0));
        while (n < 100) begin
            tick();
            if (n == 97) checkOutput("t5_ready_back", int'(cfg_ready), 1);
            checkOutput("t5_vec", observed(),
                        vec(1'b1, (n - 49) % 5 < 2, (n - 52) % 5 < 2,
                            (n - 51) % 5 == 2, (n - 51) % 5 == 0));
        end

        // Test 6: reset during RELOCK after a config, then defaults again
        applyStimulus(1'b1, 2'd1, 16'd3, 16'd0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        tick();
        checkOutput("t6_locked_drop", int'(locked), 0);
        rst_n = 1'b0;
        applyStimulus(1'b1, 2'd1, 16'd7, 16'd2, 1'b0);
        #1;
        checkOutput("t6_ready_in_rst", int'(cfg_ready), 0);
        tick();
        checkOutput("t6_rst_outputs", observed(), 0);
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        resetDut();
        runDefault("t6_default");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
